// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Consumers import seg_arb_pkg::* for the state enum and segment byte type.
package seg_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWNED = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    typedef logic [7:0] seg_byte_t;

    // Segments are active-low, so all-ones turns every segment and the dot off.
    localparam seg_byte_t SEG_BLANK = 8'hFF;

    localparam int unsigned SEG_DIGITS  = 4;
    localparam int unsigned SEG_FRAME_W = 32;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bus of the 7-segment arbiter.
// master = requesters + display controller side, slave = the arbiter.
interface seg_display_arbiter_if
    import seg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) ();
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic                     tick;
    logic [N_REQ-1:0]         req;
    logic [32*N_REQ-1:0]      frame;
    logic [N_REQ-1:0]         grant;
    logic [IDX_W-1:0]         owner;
    logic                     busy;
    seg_byte_t                data_0;
    seg_byte_t                data_1;
    seg_byte_t                data_2;
    seg_byte_t                data_3;

    modport master (
        output tick, req, frame,
        input  grant, owner, busy, data_0, data_1, data_2, data_3
    );

    modport slave (
        input  tick, req, frame,
        output grant, owner, busy, data_0, data_1, data_2, data_3
    );

endinterface

// File: rtl/seg_rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping N_REQ-1 -> 0 (N_REQ need not be a power of two).
module seg_rr_picker #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick_onehot_c,
    output logic [IDX_W-1:0] pick_idx_c,
    output logic             pick_valid_c
);

    logic [IDX_W:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        pick_idx_c   = '0;
        pick_valid_c = 1'b0;
        cand         = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick_idx_c   = cand[IDX_W-1:0];
                pick_valid_c = 1'b1;
            end
        end
    end

    assign pick_onehot_c = pick_valid_c ? (N_REQ'(1) << pick_idx_c) : '0;

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 4-digit 7-seg display with min/max hold in ticks.
// Optional feature: define SEG_ARB_PRIO0_EN to make requester 0 urgent.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MIN_HOLD = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic                  clk,
    input logic                  rst,
    seg_display_arbiter_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t        state, state_n;
    logic [N_REQ-1:0]  grant, grant_n;
    logic [IDX_W-1:0]  owner, owner_n;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_n;
    logic              busy, busy_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    seg_byte_t         data_q [SEG_DIGITS];
    seg_byte_t         data_n [SEG_DIGITS];

    logic [N_REQ-1:0]       pick_onehot_c, idle_onehot_c;
    logic [IDX_W-1:0]       pick_idx_c, idle_idx_c, rr_next_c;
    logic                   pick_valid_c, idle_valid_c;
    logic [N_REQ-1:0]       owner_mask_c;
    logic                   owner_req_c, other_req_c, urgent_c;
    logic                   min_met_c, max_hit_c, release_c;
    logic [SEG_FRAME_W-1:0] owner_frame_c;

    seg_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req           (bus.req),
        .rr_ptr        (rr_ptr),
        .pick_onehot_c (pick_onehot_c),
        .pick_idx_c    (pick_idx_c),
        .pick_valid_c  (pick_valid_c)
    );

`ifdef SEG_ARB_PRIO0_EN
    // Requester 0 jumps the queue in IDLE and evicts any other owner at once.
    assign idle_valid_c  = pick_valid_c | bus.req[0];
    assign idle_idx_c    = bus.req[0] ? '0 : pick_idx_c;
    assign idle_onehot_c = bus.req[0] ? N_REQ'(1) : pick_onehot_c;
    assign urgent_c      = bus.req[0] && (owner != '0);
`else
    assign idle_valid_c  = pick_valid_c;
    assign idle_idx_c    = pick_idx_c;
    assign idle_onehot_c = pick_onehot_c;
    assign urgent_c      = 1'b0;
`endif

    assign owner_mask_c  = N_REQ'(1) << owner;
    assign owner_req_c   = |(bus.req & owner_mask_c);
    assign other_req_c   = |(bus.req & ~owner_mask_c);
    assign owner_frame_c = bus.frame[{owner, 5'd0} +: SEG_FRAME_W];
    assign max_hit_c     = (hold_cnt == HOLD_W'(MAX_HOLD));
    assign rr_next_c     = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);

    generate
        if (MIN_HOLD == 0) begin : g_no_min
            assign min_met_c = 1'b1;
        end else begin : g_min
            assign min_met_c = (hold_cnt >= HOLD_W'(MIN_HOLD));
        end
    endgenerate

    assign release_c = (!owner_req_c && min_met_c) || (max_hit_c && other_req_c) || urgent_c;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        busy_n     = busy;
        hold_cnt_n = hold_cnt;
        data_n     = data_q;
        case (state)
            ARB_IDLE: begin
                if (idle_valid_c) begin
                    state_n    = ARB_OWNED;
                    grant_n    = idle_onehot_c;
                    owner_n    = idle_idx_c;
                    busy_n     = 1'b1;
                    hold_cnt_n = '0;
                end
            end
            ARB_OWNED: begin
                if (release_c) begin
                    state_n  = ARB_GAP;
                    grant_n  = '0;
                    busy_n   = 1'b0;
                    rr_ptr_n = rr_next_c;
                    for (int k = 0; k < SEG_DIGITS; k++) begin
                        data_n[k] = SEG_BLANK;
                    end
                end else begin
                    if (bus.tick && !max_hit_c) begin
                        hold_cnt_n = hold_cnt + HOLD_W'(1);
                    end
                    if (owner_req_c) begin
                        for (int k = 0; k < SEG_DIGITS; k++) begin
                            data_n[k] = owner_frame_c[8*k +: 8];
                        end
                    end
                end
            end
            ARB_GAP: begin
                state_n = ARB_IDLE;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            for (int k = 0; k < SEG_DIGITS; k++) begin
                data_q[k] <= SEG_BLANK;
            end
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            busy     <= busy_n;
            hold_cnt <= hold_cnt_n;
            for (int k = 0; k < SEG_DIGITS; k++) begin
                data_q[k] <= data_n[k];
            end
        end
    end

    assign bus.grant  = grant;
    assign bus.owner  = owner;
    assign bus.busy   = busy;
    assign bus.data_0 = data_q[0];
    assign bus.data_1 = data_q[1];
    assign bus.data_2 = data_q[2];
    assign bus.data_3 = data_q[3];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter (N_REQ=4, MIN_HOLD=4, MAX_HOLD=16).
// Honours SEG_ARB_PRIO0_EN when it is defined for the build.
module tb_seg_display_arbiter;
    import seg_arb_pkg::*;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned MIN_HOLD = 4;
    localparam int unsigned MAX_HOLD = 16;

    localparam logic [31:0] F0  = 32'h1122_3344;
    localparam logic [31:0] F1  = 32'hC0F9_A4B0;
    localparam logic [31:0] F2  = 32'h5566_7788;
    localparam logic [31:0] F3  = 32'h99AA_BBCC;
    localparam logic [31:0] BLK = 32'hFFFF_FFFF;

`ifdef SEG_ARB_PRIO0_EN
    localparam logic [3:0] RR_REQ = 4'b1110;
`else
    localparam logic [3:0] RR_REQ = 4'b1111;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [31:0] fr [4];

    always #5 clk = ~clk;

    seg_display_arbiter_if #(.N_REQ(N_REQ)) bus ();
    assign bus.frame = {fr[3], fr[2], fr[1], fr[0]};

    seg_display_arbiter #(
        .N_REQ    (N_REQ),
        .MIN_HOLD (MIN_HOLD),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        busy;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic       r;
        logic       t;
        logic [3:0] rq;
        exp_t       e;
    } vec_t;

    vec_t  vecs [$];
    exp_t  sb_q [$];
    string nm_q [$];
    int    checks = 0;
    int    errors = 0;

    function automatic exp_t mk(logic [3:0] g, logic [1:0] o, logic b, logic [31:0] d);
        exp_t e;
        e.grant = g;
        e.owner = o;
        e.busy  = b;
        e.data  = d;
        return e;
    endfunction

    task automatic add_vec(input logic r, input logic t, input logic [3:0] rq, input exp_t e);
        vec_t v;
        v.r  = r;
        v.t  = t;
        v.rq = rq;
        v.e  = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic pop_check();
        exp_t  e;
        exp_t  a;
        string nm;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got 0 entries want 1");
            return;
        end
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        a  = mk(bus.grant, bus.owner, bus.busy, {bus.data_3, bus.data_2, bus.data_1, bus.data_0});
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got grant=%b owner=%0d busy=%b data=%h want grant=%b owner=%0d busy=%b data=%h",
                     nm, a.grant, a.owner, a.busy, a.data, e.grant, e.owner, e.busy, e.data);
        end
    endtask

    task automatic step(input logic r, input logic t, input logic [3:0] rq);
        rst      = r;
        bus.tick = t;
        bus.req  = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string nm, input logic r, input logic t, input logic [3:0] rq, input exp_t e);
        sb_q.push_back(e);
        nm_q.push_back(nm);
        step(r, t, rq);
        pop_check();
    endtask

    initial begin
        int rr_owner [5];
        int bad;
        int wait_c;
        int ticks;
        int gap;
        logic tk;

        rst      = 1'b1;
        bus.tick = 1'b0;
        bus.req  = '0;
        fr[0] = F0; fr[1] = F1; fr[2] = F2; fr[3] = F3;

        // Single request, early release of owner 1, arbitration from rr_ptr=2, reset mid-OWNED
        add_vec(1, 0, 4'b0000, mk(4'b0000, 0, 0, BLK));
        add_vec(0, 0, 4'b0010, mk(4'b0010, 1, 1, BLK));
        add_vec(0, 0, 4'b0010, mk(4'b0010, 1, 1, F1));
        add_vec(0, 1, 4'b0010, mk(4'b0010, 1, 1, F1));
        add_vec(0, 0, 4'b0000, mk(4'b0010, 1, 1, F1));
        add_vec(0, 1, 4'b0000, mk(4'b0010, 1, 1, F1));
        add_vec(0, 1, 4'b0000, mk(4'b0010, 1, 1, F1));
        add_vec(0, 1, 4'b0000, mk(4'b0010, 1, 1, F1));
        add_vec(0, 0, 4'b0000, mk(4'b0000, 1, 0, BLK));
        add_vec(0, 0, 4'b1110, mk(4'b0000, 1, 0, BLK));
        add_vec(0, 0, 4'b1110, mk(4'b0100, 2, 1, BLK));
        add_vec(0, 0, 4'b1110, mk(4'b0100, 2, 1, F2));
        add_vec(0, 0, 4'b0000, mk(4'b0100, 2, 1, F2));
        add_vec(0, 0, 4'b0100, mk(4'b0100, 2, 1, F2));
        add_vec(1, 0, 4'b0100, mk(4'b0000, 0, 0, BLK));
        add_vec(0, 0, 4'b1111, mk(4'b0001, 0, 1, BLK));
        add_vec(0, 0, 4'b1111, mk(4'b0001, 0, 1, F0));
        add_vec(1, 0, 4'b0000, mk(4'b0000, 0, 0, BLK));

        for (int i = 0; i < vecs.size(); i++) begin
            step_chk($sformatf("vec%0d", i), vecs[i].r, vecs[i].t, vecs[i].rq, vecs[i].e);
        end

        // Early release with a frozen frame: owner 2 drops req after one tick
        step(1, 0, 4'b0000);
        step_chk("er_grant", 0, 0, 4'b0100, mk(4'b0100, 2, 1, BLK));
        step_chk("er_data",  0, 0, 4'b0100, mk(4'b0100, 2, 1, F2));
        step_chk("er_tick1", 0, 1, 4'b0100, mk(4'b0100, 2, 1, F2));
        fr[2] = 32'hDEAD_BEEF;
        step_chk("er_frozen", 0, 0, 4'b0000, mk(4'b0100, 2, 1, F2));
        for (int i = 0; i < 3; i++) begin
            step_chk($sformatf("er_hold%0d", i + 2), 0, 1, 4'b0000, mk(4'b0100, 2, 1, F2));
        end
        step_chk("er_gap",  0, 0, 4'b0000, mk(4'b0000, 2, 0, BLK));
        step_chk("er_idle", 0, 0, 4'b0000, mk(4'b0000, 2, 0, BLK));
        fr[2] = F2;

        // Round robin with all requesters held; 16 ticks each, blank + arbitration cycle between
`ifdef SEG_ARB_PRIO0_EN
        rr_owner = '{1, 2, 3, 1, 2};
`else
        rr_owner = '{0, 1, 2, 3, 0};
`endif
        step(1, 0, RR_REQ);
        for (int n = 0; n < 5; n++) begin
            wait_c = 0;
            while (bus.grant == 4'b0000 && wait_c < 10) begin
                step(0, 0, RR_REQ);
                wait_c++;
            end
            check($sformatf("rr%0d_grant", n), 64'(bus.grant), 64'(4'b0001) << rr_owner[n]);
            check($sformatf("rr%0d_owner", n), 64'(bus.owner), 64'(rr_owner[n]));
            wait_c = 0;
            ticks  = 0;
            while (bus.grant != 4'b0000 && wait_c < 80) begin
                tk = wait_c[0];
                step(0, tk, RR_REQ);
                if (tk && bus.grant != 4'b0000) ticks++;
                wait_c++;
            end
            check($sformatf("rr%0d_ticks", n), 64'(ticks), 64'(MAX_HOLD));
            check($sformatf("rr%0d_gap_data", n),
                  64'({bus.data_3, bus.data_2, bus.data_1, bus.data_0}), 64'(BLK));
            check($sformatf("rr%0d_gap_busy", n), 64'(bus.busy), 64'(0));
            gap = 0;
            while (bus.grant == 4'b0000 && gap < 10) begin
                gap++;
                step(0, 0, RR_REQ);
            end
            check($sformatf("rr%0d_gap_len", n), 64'(gap), 64'(2));
        end

        // Sole requester holds through 40 ticks; saturated counter then yields to a newcomer
        step(1, 0, 4'b0001);
        step_chk("solo_grant", 0, 0, 4'b0001, mk(4'b0001, 0, 1, BLK));
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            tk = i[0];
            step(0, tk, 4'b0001);
            if (bus.grant != 4'b0001 || bus.busy != 1'b1) bad++;
        end
        check("solo_no_gap", 64'(bad), 64'(0));
        check("solo_hold_sat", 64'(dut.hold_cnt), 64'(MAX_HOLD));
        step_chk("solo_data", 0, 0, 4'b0001, mk(4'b0001, 0, 1, F0));
        step_chk("solo_preempt", 0, 0, 4'b0011, mk(4'b0000, 0, 0, BLK));
        step_chk("solo_idle",    0, 0, 4'b0011, mk(4'b0000, 0, 0, BLK));
        step_chk("solo_next",    0, 0, 4'b0011, mk(4'b0010, 1, 1, BLK));

        // Requester 0 rising while owner 3 has one tick of hold
        step(1, 0, 4'b1000);
        step_chk("p_grant", 0, 0, 4'b1000, mk(4'b1000, 3, 1, BLK));
        step_chk("p_tick",  0, 1, 4'b1000, mk(4'b1000, 3, 1, F3));
`ifdef SEG_ARB_PRIO0_EN
        step_chk("p_gap",    0, 0, 4'b1001, mk(4'b0000, 3, 0, BLK));
        step_chk("p_idle",   0, 0, 4'b1001, mk(4'b0000, 3, 0, BLK));
        step_chk("p_owner0", 0, 0, 4'b1001, mk(4'b0001, 0, 1, BLK));
`else
        for (int i = 0; i < 3; i++) begin
            step_chk($sformatf("p_keep%0d", i), 0, 0, 4'b1001, mk(4'b1000, 3, 1, F3));
        end
`endif

        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
